// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator: state encoding and counter sizing.
// The GAP state is only present when SEQGEN_GAP_EN is defined.
package seq_gen_pkg;

`ifdef SEQGEN_GAP_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1
   } state_t;
`endif

   // Bits needed for a counter running 0..n-1 (never less than one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Pattern holding register: loads a pattern, steps through it MSB first and reloads from
// its private copy after bit 0 so every repetition starts from the latched pattern.
module seq_gen_shifter
   import seq_gen_pkg::*;
#(
   parameter int PAT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_adv,
   input  logic [PAT_W-1:0] i_pattern,
   output logic             o_next_bit,
   output logic             o_last
);

   localparam int              BW      = cnt_w(PAT_W);
   localparam logic [BW-1:0]   BIT_TOP = BW'(PAT_W - 1);

   logic [PAT_W-1:0] r_sh;
   logic [PAT_W-1:0] r_copy;
   logic [BW-1:0]    r_bit;

   // r_sh[MSB] is the bit currently on the line; r_bit is its index in the pattern.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sh   <= '0;
         r_copy <= '0;
         r_bit  <= '0;
      end else if (i_load) begin
         r_sh   <= i_pattern;
         r_copy <= i_pattern;
         r_bit  <= BIT_TOP;
      end else if (i_adv) begin
         if (r_bit == '0) begin
            r_sh  <= r_copy;
            r_bit <= BIT_TOP;
         end else begin
            r_sh  <= {r_sh[PAT_W-2:0], r_sh[PAT_W-1]};
            r_bit <= r_bit - BW'(1);
         end
      end
   end

   assign o_last     = (r_bit == '0);
   assign o_next_bit = o_last ? r_copy[PAT_W-1] : r_sh[PAT_W-2];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial stimulus transmitter: sends a latched pattern MSB first on o_x, i_reps times.
// Define SEQGEN_GAP_EN to insert GAP_LEN idle cycles between repetitions.
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int REP_W = 4
`ifdef SEQGEN_GAP_EN
   , parameter int GAP_LEN = 2
`endif
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [PAT_W-1:0] i_pattern,
   input  logic [REP_W-1:0] i_reps,
   output logic             o_x,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_done,
   output state_t           o_state
);

   state_t           r_state, w_state_nxt;
   logic [REP_W-1:0] r_rep, w_rep_nxt;
   logic             r_x, r_valid, r_busy, r_done;
   logic             w_x_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;
   logic             w_load, w_adv, w_next_bit, w_last;

`ifdef SEQGEN_GAP_EN
   localparam int            GW       = cnt_w(GAP_LEN);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
   logic [GW-1:0] r_gap, w_gap_nxt;
`endif

   seq_gen_shifter #(.PAT_W(PAT_W)) u_shifter (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_adv      (w_adv),
      .i_pattern  (i_pattern),
      .o_next_bit (w_next_bit),
      .o_last     (w_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_rep   <= '0;
         r_x     <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef SEQGEN_GAP_EN
         r_gap   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_rep   <= w_rep_nxt;
         r_x     <= w_x_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
`ifdef SEQGEN_GAP_EN
         r_gap   <= w_gap_nxt;
`endif
      end
   end

   // Next-state logic computes the next value of every output register directly.
   always_comb begin
      w_state_nxt = r_state;
      w_rep_nxt   = r_rep;
      w_x_nxt     = 1'b0;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      w_adv       = 1'b0;
`ifdef SEQGEN_GAP_EN
      w_gap_nxt   = r_gap;
`endif
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_reps != '0) begin
                  w_load      = 1'b1;
                  w_rep_nxt   = i_reps;
                  w_state_nxt = ST_SHIFT;
                  w_x_nxt     = i_pattern[PAT_W-1];
                  w_valid_nxt = 1'b1;
                  w_busy_nxt  = 1'b1;
               end else begin
                  w_done_nxt  = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (!w_last) begin
               w_adv       = 1'b1;
               w_x_nxt     = w_next_bit;
               w_valid_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
            end else if (r_rep > REP_W'(1)) begin
               w_rep_nxt  = r_rep - REP_W'(1);
               w_busy_nxt = 1'b1;
`ifdef SEQGEN_GAP_EN
               if (GAP_LEN > 0) begin
                  w_state_nxt = ST_GAP;
                  w_gap_nxt   = '0;
               end else begin
                  w_adv       = 1'b1;
                  w_x_nxt     = w_next_bit;
                  w_valid_nxt = 1'b1;
               end
`else
               w_adv       = 1'b1;
               w_x_nxt     = w_next_bit;
               w_valid_nxt = 1'b1;
`endif
            end else begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
`ifdef SEQGEN_GAP_EN
         ST_GAP: begin
            w_busy_nxt = 1'b1;
            if (r_gap == GAP_LAST) begin
               w_state_nxt = ST_SHIFT;
               w_adv       = 1'b1;
               w_x_nxt     = w_next_bit;
               w_valid_nxt = 1'b1;
            end else begin
               w_gap_nxt = r_gap + GW'(1);
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_x     = r_x;
   assign o_valid = r_valid;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_state = r_state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen (default build, back-to-back repetitions),
// including a loopback into a non-overlapping Moore 1010 detector.
module tb_seq_pattern_gen;
   import seq_gen_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [3:0] pattern, reps;
   logic       x, valid, busy, done;
   state_t     state;
   int         n_checks = 0;
   int         n_err    = 0;

   always #5 clk = ~clk;

   seq_pattern_gen #(.PAT_W(4), .REP_W(4)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_pattern (pattern),
      .i_reps    (reps),
      .o_x       (x),
      .o_valid   (valid),
      .o_busy    (busy),
      .o_done    (done),
      .o_state   (state)
   );

   // Reference non-overlapping Moore 1010 detector fed by x.
   typedef enum logic [2:0] {D0, D1, D10, D101, D1010} det_t;
   det_t det;
   logic z;
   int   z_cnt = 0;
   assign z = (det == D1010);
   always @(posedge clk) begin
      if (rst) det <= D0;
      else begin
         case (det)
            D0:      det <= x ? D1 : D0;
            D1:      det <= x ? D1 : D10;
            D10:     det <= x ? D101 : D0;
            D101:    det <= x ? D1 : D1010;
            default: det <= x ? D1 : D0;
         endcase
      end
      if (z) z_cnt <= z_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks `count` bits of a `total`-bit MSB-first stream; optionally re-pulses start mid-run.
   task automatic stream(input string tag, input logic [63:0] bits, input int total,
                         input int count, input int repulse_at);
      for (int k = 0; k < count; k++) begin
         chk({tag, "_x"}, {31'd0, x}, {31'd0, bits[total-1-k]});
         chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         if (k == repulse_at) begin
            start   = 1'b1;
            pattern = 4'b0001;
            reps    = 4'd1;
         end else if (k == repulse_at + 1) begin
            start = 1'b0;
         end
         step();
      end
   endtask

   task automatic chk_done(input string tag);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_dbusy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_dvalid"}, {31'd0, valid}, 32'd0);
      chk({tag, "_dx"}, {31'd0, x}, 32'd0);
   endtask

   task automatic launch(input logic [3:0] p, input logic [3:0] r);
      pattern = p;
      reps    = r;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   int z_base;

   initial begin
      rst = 1'b1; start = 1'b0; pattern = '0; reps = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_x", {31'd0, x}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_state", {30'd0, state}, {30'd0, ST_IDLE});

      // Basic 1010 x3.
      launch(4'b1010, 4'd3);
      chk("t1_state", {30'd0, state}, {30'd0, ST_SHIFT});
      stream("t1", 64'b1010_1010_1010, 12, 12, -10);
      chk_done("t1");
      step();
      chk("t1_done_clr", {31'd0, done}, 32'd0);

      // reps = 0: done only.
      launch(4'b1111, 4'd0);
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_busy", {31'd0, busy}, 32'd0);
      chk("t2_valid", {31'd0, valid}, 32'd0);
      chk("t2_x", {31'd0, x}, 32'd0);
      step();
      chk("t2_done_clr", {31'd0, done}, 32'd0);
      chk("t2_busy2", {31'd0, busy}, 32'd0);

      // Start while busy is ignored.
      launch(4'b1100, 4'd2);
      stream("t3", 64'b1100_1100, 8, 8, 2);
      chk_done("t3");
      step();
      chk("t3_idle", {31'd0, busy}, 32'd0);

      // Reset mid-stream aborts with no done.
      launch(4'b1011, 4'd5);
      stream("t4", {44'd0, {5{4'b1011}}}, 20, 5, -10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t4_x", {31'd0, x}, 32'd0);
      chk("t4_valid", {31'd0, valid}, 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_done", {31'd0, done}, 32'd0);
      chk("t4_state", {30'd0, state}, {30'd0, ST_IDLE});
      step();
      chk("t4_nodone", {31'd0, done}, 32'd0);
      launch(4'b0110, 4'd1);
      stream("t4b", 64'b0110, 4, 4, -10);
      chk_done("t4b");
      step(); step();

      // Maximum repeat count, no wrap.
      launch(4'b0110, 4'd15);
      stream("t7", {4'd0, {15{4'b0110}}}, 60, 60, -10);
      chk_done("t7");
      step(); step(); step();

      // Loopback with a back-to-back start in the done cycle.
      z_base = z_cnt;
      launch(4'b1010, 4'd3);
      stream("t6a", 64'b1010_1010_1010, 12, 12, -10);
      chk_done("t6a");
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t6_z3", z_cnt - z_base, 32'd3);
      stream("t6b", 64'b1010_1010_1010, 12, 12, -10);
      chk_done("t6b");
      step(); step();
      chk("t6_z6", z_cnt - z_base, 32'd6);
      chk("t6_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
